// File: rtl/riscv_regfile_sb.sv
// Integer register file with a per-register busy scoreboard. It issues operands to the EXU
// one cycle after an accept and takes EXU writebacks, which clear the busy bit.
module riscv_regfile_sb #(
    parameter int unsigned BYPASS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_vld,
    output logic        issue_rdy,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_en,
    output logic        disp_vld,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] busy,
    output logic        sb_err
);

    logic [31:0] regs [32];
    logic [31:0] eb;
    logic [31:0] busy_nxt;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        wb_fwd;
    logic        accept;

    assign wb_fwd = (BYPASS != 0) && wb_en && (wb_rd != '0);

    // A register being written back this cycle is usable by the issuing instruction when forwarding is on
    always_comb begin
        eb = busy;
        if (wb_fwd) eb[wb_rd] = 1'b0;
    end

    assign issue_rdy = ~reset & ~eb[issue_rs1] & ~eb[issue_rs2] & ~(issue_rd_en & eb[issue_rd]);
    assign accept    = issue_vld & issue_rdy;

    always_comb begin
        rs1_val = regs[issue_rs1];
        if (issue_rs1 == '0)                    rs1_val = '0;
        else if (wb_fwd && wb_rd == issue_rs1)  rs1_val = wb_data;
        rs2_val = regs[issue_rs2];
        if (issue_rs2 == '0)                    rs2_val = '0;
        else if (wb_fwd && wb_rd == issue_rs2)  rs2_val = wb_data;
    end

    // Clear before set: a register released and re-reserved in the same cycle stays busy
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_rd] = 1'b0;
        if (accept && issue_rd_en && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            busy     <= '0;
            disp_vld <= 1'b0;
            rs1_data <= '0;
            rs2_data <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            disp_vld <= accept;
            if (accept) begin
                rs1_data <= rs1_val;
                rs2_data <= rs2_val;
            end
            if (wb_en && wb_rd != '0) begin
                regs[wb_rd] <= wb_data;
                if (!busy[wb_rd]) sb_err <= 1'b1;
            end
        end
    end

endmodule
